transmissor_stdout: RTL and testbench

TRANSMISSOR_STDOUT -- requirements
Module: transmissor_stdout

---
 rtl/transmissor_stdout.sv | 178 +++++++++++++++++
 tb/tb_transmissor_stdout.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transmissor_stdout.sv
// UART 8N1 transmitter for processor stdout.
// Each write strobe queues the low byte of the word in a small FIFO. An FSM then
// serialises the queued bytes, LSB first, sending frames back to back while data remains.
module transmissor_stdout #(
    parameter int unsigned CLKS_POR_BIT = 434,
    parameter int unsigned FIFO_PROF    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dado,
    input  logic        escreve,
    output logic        tx,
    output logic        ocupado,
    output logic        cheio,
    output logic [7:0]  perdidos
);

    localparam int unsigned PTR_W = $clog2(FIFO_PROF);
    localparam int unsigned CNT_W = $clog2(FIFO_PROF + 1);
    localparam logic [15:0] BAUD_ULT = 16'(CLKS_POR_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_CHEIO = CNT_W'(FIFO_PROF);

    typedef enum logic [1:0] {StOcioso, StInicio, StDados, StParada} estado_e;

    estado_e          estado_q, estado_d;
    logic             tx_q, tx_d;
    logic [15:0]      baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       perdidos_q, perdidos_d;
    logic [7:0]       mem_q [FIFO_PROF];

    logic       pop;
    logic       push;
    logic       drop;
    logic       vazio;
    logic       cheio_w;
    logic       baud_fim;
    logic [2:0] bit_prox;
    logic [7:0] cabeca;
    logic       unused_dado;

    // Only the low byte is ever transmitted.
    assign unused_dado = ^dado[31:8];

    assign vazio    = (count_q == '0);
    assign cheio_w  = (count_q == CNT_CHEIO);
    assign baud_fim = (baud_q == BAUD_ULT);
    assign bit_prox = bit_q + 3'd1;
    assign cabeca   = mem_q[rd_ptr_q];

    // FIFO bookkeeping; a pop on the same edge frees the slot a full-FIFO push needs.
    always_comb begin
        push       = escreve && (!cheio_w || pop);
        drop       = escreve && cheio_w && !pop;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        perdidos_d = perdidos_q;
        if (drop && (perdidos_q != 8'hFF)) begin
            perdidos_d = perdidos_q + 8'd1;
        end
    end

    // Frame sequencing; tx_d is the line level for the state being entered.
    always_comb begin
        estado_d = estado_q;
        tx_d     = tx_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pop      = 1'b0;
        case (estado_q)
            StOcioso: begin
                tx_d = 1'b1;
                if (!vazio) begin
                    pop      = 1'b1;
                    shift_d  = cabeca;
                    baud_d   = '0;
                    bit_d    = '0;
                    estado_d = StInicio;
                    tx_d     = 1'b0;
                end
            end
            StInicio: begin
                if (baud_fim) begin
                    baud_d   = '0;
                    bit_d    = '0;
                    estado_d = StDados;
                    tx_d     = shift_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            StDados: begin
                if (baud_fim) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        estado_d = StParada;
                        tx_d     = 1'b1;
                    end else begin
                        bit_d = bit_prox;
                        tx_d  = shift_q[bit_prox];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            StParada: begin
                if (baud_fim) begin
                    baud_d = '0;
                    if (!vazio) begin
                        pop      = 1'b1;
                        shift_d  = cabeca;
                        bit_d    = '0;
                        estado_d = StInicio;
                        tx_d     = 1'b0;
                    end else begin
                        estado_d = StOcioso;
                        tx_d     = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                estado_d = StOcioso;
                tx_d     = 1'b1;
            end
        endcase
    end

    // State, counters and the registered line driver, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= StOcioso;
            tx_q       <= 1'b1;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            perdidos_q <= '0;
        end else begin
            estado_q   <= estado_d;
            tx_q       <= tx_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            perdidos_q <= perdidos_d;
        end
    end

    // Byte storage; contents are meaningless once pointers and count are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dado[7:0];
        end
    end

    assign tx       = tx_q;
    assign ocupado  = (estado_q != StOcioso) || !vazio;
    assign cheio    = cheio_w;
    assign perdidos = perdidos_q;

endmodule

// File: tb/tb_transmissor_stdout.sv
// Self-checking bench for transmissor_stdout with 4 clocks per bit and a 4-byte FIFO.
// Expected bytes are queued as they are written; a line monitor decodes frames and
// the scoreboard compares them in order.
module tb_transmissor_stdout;

    logic        clk;
    logic        rst_n;
    logic [31:0] dado;
    logic        escreve;
    logic        tx;
    logic        ocupado;
    logic        cheio;
    logic [7:0]  perdidos;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q[$];
    logic [9:0]  rx_q[$];
    int unsigned starts_q[$];
    int unsigned cyc = 0;
    bit          mon_busy = 1'b0;
    int          mon_pos = 0;
    logic [9:0]  mon_frame = '0;

    transmissor_stdout #(
        .CLKS_POR_BIT(4),
        .FIFO_PROF   (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dado    (dado),
        .escreve (escreve),
        .tx      (tx),
        .ocupado (ocupado),
        .cheio   (cheio),
        .perdidos(perdidos)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Line monitor: samples mid-bit on falling clock edges, 10 samples per frame.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_busy = 1'b0;
            end else if (!mon_busy) begin
                if (tx === 1'b0) begin
                    mon_busy = 1'b1;
                    mon_pos  = 0;
                    starts_q.push_back(cyc);
                end
            end else begin
                mon_pos = mon_pos + 1;
                if ((mon_pos % 4) == 2) mon_frame[mon_pos / 4] = tx;
                if (mon_pos == 39) begin
                    rx_q.push_back(mon_frame);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    // Caller is at a falling edge; returns at the next falling edge with the strobe low.
    task automatic push_byte(input logic [31:0] d, input bit accept);
        dado    = d;
        escreve = 1'b1;
        if (accept) exp_q.push_back(d[7:0]);
        @(negedge clk);
        escreve = 1'b0;
    endtask

    // Pops decoded frames against the expected queue until the transmitter goes quiet.
    task automatic drain_scoreboard(input int budget);
        logic [9:0] f;
        logic [7:0] e;
        bit         done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            #1;
            while (rx_q.size() != 0) begin
                f = rx_q.pop_front();
                total++;
                if (f[0] !== 1'b0 || f[9] !== 1'b1) begin
                    bad++;
                    $display("FAIL framing: got start=%b stop=%b, required start=0 stop=1",
                             f[0], f[9]);
                end
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_frame: got data=%h, required no frame", f[8:1]);
                end else begin
                    e = exp_q.pop_front();
                    if (f[8:1] !== e) begin
                        bad++;
                        $display("FAIL frame_data: got %h, required %h", f[8:1], e);
                    end
                end
            end
            if (!ocupado && !mon_busy) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout: got ocupado=%b after %0d cycles, required 0",
                     ocupado, budget);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_frames: got %0d untransmitted, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b1;
        escreve = 1'b0;
        dado    = '0;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b, required 1", tx); end
        total++;
        if (ocupado !== 1'b0) begin
            bad++; $display("FAIL reset_ocupado: got %b, required 0", ocupado);
        end
        total++;
        if (cheio !== 1'b0) begin
            bad++; $display("FAIL reset_cheio: got %b, required 0", cheio);
        end
        total++;
        if (perdidos !== 8'd0) begin
            bad++; $display("FAIL reset_perdidos: got %0d, required 0", perdidos);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (tx !== 1'b1 || ocupado !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got tx=%b ocupado=%b, required tx=1 ocupado=0",
                     tx, ocupado);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        dado    = 32'h0000_0041;
        escreve = 1'b1;
        exp_q.push_back(8'h41);
        @(posedge clk);
        #1 escreve = 1'b0;
        total++;
        if (tx !== 1'b1 || ocupado !== 1'b1) begin
            bad++;
            $display("FAIL single_after_push: got tx=%b ocupado=%b, required tx=1 ocupado=1",
                     tx, ocupado);
        end
        @(posedge clk);
        #1;
        total++;
        if (tx !== 1'b0) begin bad++; $display("FAIL single_start_latency: got %b, required 0", tx); end
        repeat (39) @(posedge clk);
        #1;
        total++;
        if (tx !== 1'b1 || ocupado !== 1'b1) begin
            bad++;
            $display("FAIL single_last_stop_cycle: got tx=%b ocupado=%b, required 1 1",
                     tx, ocupado);
        end
        @(posedge clk);
        #1;
        total++;
        if (ocupado !== 1'b0) begin
            bad++; $display("FAIL single_ocupado_end: got %b, required 0", ocupado);
        end
        drain_scoreboard(60);
    endtask

    task automatic test_upper_bits();
        @(negedge clk);
        push_byte(32'hFFFF_FF55, 1'b1);
        drain_scoreboard(100);
    endtask

    task automatic test_back_to_back();
        starts_q.delete();
        @(negedge clk);
        for (int i = 1; i <= 5; i++) push_byte(32'(i), 1'b1);
        drain_scoreboard(400);
        total++;
        if (perdidos !== 8'd0) begin
            bad++; $display("FAIL burst_perdidos: got %0d, required 0", perdidos);
        end
        total++;
        if (starts_q.size() != 5) begin
            bad++; $display("FAIL burst_frames: got %0d, required 5", starts_q.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                total++;
                if (starts_q[i] - starts_q[i-1] != 40) begin
                    bad++;
                    $display("FAIL burst_gap: got %0d cycles, required 40",
                             starts_q[i] - starts_q[i-1]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        @(negedge clk);
        push_byte(32'h0000_00A5, 1'b1);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            push_byte(32'h0000_00B0 + 32'(i), i < 4);
            if (i == 2) begin
                total++;
                if (cheio !== 1'b0) begin
                    bad++; $display("FAIL overflow_cheio_3: got %b, required 0", cheio);
                end
            end
            if (i == 3) begin
                total++;
                if (cheio !== 1'b1) begin
                    bad++; $display("FAIL overflow_cheio_4: got %b, required 1", cheio);
                end
            end
        end
        total++;
        if (perdidos !== 8'd2) begin
            bad++; $display("FAIL overflow_perdidos: got %0d, required 2", perdidos);
        end
        drain_scoreboard(400);
        total++;
        if (cheio !== 1'b0) begin
            bad++; $display("FAIL overflow_cheio_end: got %b, required 0", cheio);
        end
    endtask

    // Which bytes slip in on pop edges is not tracked here; only the saturating counter is.
    task automatic test_saturation();
        @(negedge clk);
        for (int i = 0; i < 330; i++) push_byte(32'h0000_0060 + 32'(i % 16), 1'b0);
        total++;
        if (perdidos !== 8'd255) begin
            bad++; $display("FAIL saturation_perdidos: got %0d, required 255", perdidos);
        end
        total++;
        if (cheio !== 1'b1) begin
            bad++; $display("FAIL saturation_cheio: got %b, required 1", cheio);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (perdidos !== 8'd0) begin
            bad++; $display("FAIL saturation_clear: got %0d, required 0", perdidos);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        push_byte(32'h0000_0034, 1'b1);
        for (int i = 0; i < 4; i++) push_byte(32'h0000_0070 + 32'(i), 1'b1);
        total++;
        if (cheio !== 1'b1) begin
            bad++; $display("FAIL midreset_fill: got cheio=%b, required 1", cheio);
        end
        push_byte(32'h0000_00EE, 1'b0);
        total++;
        if (perdidos !== 8'd1) begin
            bad++; $display("FAIL midreset_drop: got %0d, required 1", perdidos);
        end
        repeat (13) @(negedge clk);
        total++;
        if (tx !== 1'b0) begin
            bad++; $display("FAIL midreset_bit3: got tx=%b, required 0", tx);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (tx !== 1'b1 || ocupado !== 1'b0 || cheio !== 1'b0 || perdidos !== 8'd0) begin
            bad++;
            $display("FAIL midreset_async: got tx=%b ocupado=%b cheio=%b perdidos=%0d, required 1 0 0 0",
                     tx, ocupado, cheio, perdidos);
        end
        exp_q.delete();
        rx_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_byte(32'h0000_00C3, 1'b1);
        drain_scoreboard(100);
        total++;
        if (perdidos !== 8'd0) begin
            bad++; $display("FAIL midreset_after: got perdidos=%0d, required 0", perdidos);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_upper_bits();
        test_back_to_back();
        test_overflow();
        test_saturation();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
